// File: rtl/sbox_scheduler.sv
// sbox_scheduler: time-shares four AES S-box lanes between a 128-bit
// SubBytes state job (four 32-bit beats) and single-cycle key-schedule
// SubWord requests. Key requests may pre-empt the state job between beats
// when KEY_PRIORITY is non-zero.

// aes_sbox: combinational AES S-box (GF(2^8) inverse followed by the affine map).
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? (p ^ x) : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Rotate left by n bit positions (n in 1..4).
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // AES affine transform: b = x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  assign out_o = affine(gf_inv(in_i));

endmodule

module sbox_scheduler #(
  parameter int unsigned KEY_PRIORITY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  input  logic [127:0] st_data,
  output logic         st_ready,
  output logic         st_out_valid,
  output logic [127:0] st_out_data,
  input  logic         st_out_ready,
  input  logic         kw_valid,
  input  logic [31:0]  kw_data,
  output logic         kw_ready,
  output logic         kw_out_valid,
  output logic [31:0]  kw_out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic KEY_PRE = (KEY_PRIORITY != 32'd0);

  state_e        state_q, state_d;
  logic [1:0]    beat_q;
  logic [127:0]  st_buf_q;
  logic          st_ready_q, st_ready_d;
  logic          kw_ready_q, kw_ready_d;
  logic          st_out_valid_q;
  logic [127:0]  st_out_data_q;
  logic          kw_out_valid_q;
  logic [31:0]   kw_out_data_q;

  logic          st_accept_s;
  logic          kw_accept_s;
  logic          beat_run_s;
  logic [31:0]   st_word_s;
  logic [31:0]   lane_in_s;
  logic [31:0]   lane_out_s;

  assign st_accept_s = st_valid & st_ready_q;
  assign kw_accept_s = kw_valid & kw_ready_q;
  // A key accept owns the lanes, so the state beat only runs when none is taken.
  assign beat_run_s  = (state_q == BUSY) & ~kw_accept_s;

  // Select the captured state word for the current beat (word 0 is bits 127:96).
  always_comb begin
    st_word_s = 32'h0000_0000;
    case (beat_q)
      2'd0:    st_word_s = st_buf_q[127:96];
      2'd1:    st_word_s = st_buf_q[95:64];
      2'd2:    st_word_s = st_buf_q[63:32];
      2'd3:    st_word_s = st_buf_q[31:0];
      default: st_word_s = 32'h0000_0000;
    endcase
  end

  // Lane input mux: the key word wins the lanes on its accept cycle.
  always_comb begin
    lane_in_s = st_word_s;
    if (kw_accept_s) begin
      lane_in_s = kw_data;
    end else begin
      lane_in_s = st_word_s;
    end
  end

  // Four shared S-box lanes; lane i handles byte bits[31-8*i -: 8] of the word.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    aes_sbox u_sbox (
      .in_i  (lane_in_s[31-8*i -: 8]),
      .out_o (lane_out_s[31-8*i -: 8])
    );
  end

  // Next-state and next-ready decode for the state-job controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (st_accept_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (beat_run_s && (beat_q == 2'd3)) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (st_out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    st_ready_d = (state_d == IDLE);
    kw_ready_d = (state_d == BUSY) ? KEY_PRE : 1'b1;
  end

  // Controller registers: FSM, beat counter, captured job and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      beat_q         <= 2'd0;
      st_buf_q       <= 128'h0;
      st_ready_q     <= 1'b0;
      kw_ready_q     <= 1'b0;
      st_out_valid_q <= 1'b0;
      st_out_data_q  <= 128'h0;
      kw_out_valid_q <= 1'b0;
      kw_out_data_q  <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      st_ready_q     <= st_ready_d;
      kw_ready_q     <= kw_ready_d;
      kw_out_valid_q <= kw_accept_s;
      if (kw_accept_s) begin
        kw_out_data_q <= lane_out_s;
      end
      if (st_accept_s) begin
        st_buf_q <= st_data;
        beat_q   <= 2'd0;
      end else if (beat_run_s) begin
        case (beat_q)
          2'd0:    st_out_data_q[127:96] <= lane_out_s;
          2'd1:    st_out_data_q[95:64]  <= lane_out_s;
          2'd2:    st_out_data_q[63:32]  <= lane_out_s;
          2'd3:    st_out_data_q[31:0]   <= lane_out_s;
          default: st_out_data_q         <= st_out_data_q;
        endcase
        // The last beat leaves BUSY, so the counter saturates rather than wraps.
        if (beat_q != 2'd3) begin
          beat_q <= beat_q + 2'd1;
        end
      end
      if (beat_run_s && (beat_q == 2'd3)) begin
        st_out_valid_q <= 1'b1;
      end else if ((state_q == DONE) && st_out_ready) begin
        st_out_valid_q <= 1'b0;
      end
    end
  end

  assign st_ready     = st_ready_q;
  assign kw_ready     = kw_ready_q;
  assign st_out_valid = st_out_valid_q;
  assign st_out_data  = st_out_data_q;
  assign kw_out_valid = kw_out_valid_q;
  assign kw_out_data  = kw_out_data_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Testbench for sbox_scheduler: two instances (index 0 with KEY_PRIORITY=1,
// index 1 with KEY_PRIORITY=0) checked against a table-driven AES model.
module tb_sbox_scheduler;

  localparam logic [7:0] SBOX_TBL [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] ZERO_OUT = 128'h63636363_63636363_63636363_63636363;

  logic         clk = 1'b0;
  logic [1:0]   rst_n = 2'b11;
  logic [1:0]   st_valid, st_ready, st_out_valid, st_out_ready;
  logic [1:0]   kw_valid, kw_ready, kw_out_valid;
  logic [127:0] st_data [2];
  logic [127:0] st_out_data [2];
  logic [31:0]  kw_data [2];
  logic [31:0]  kw_out_data [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sbox_scheduler #(.KEY_PRIORITY(1)) u_dut_kp1 (
    .clk(clk), .rst_n(rst_n[0]),
    .st_valid(st_valid[0]), .st_data(st_data[0]), .st_ready(st_ready[0]),
    .st_out_valid(st_out_valid[0]), .st_out_data(st_out_data[0]), .st_out_ready(st_out_ready[0]),
    .kw_valid(kw_valid[0]), .kw_data(kw_data[0]), .kw_ready(kw_ready[0]),
    .kw_out_valid(kw_out_valid[0]), .kw_out_data(kw_out_data[0])
  );

  sbox_scheduler #(.KEY_PRIORITY(0)) u_dut_kp0 (
    .clk(clk), .rst_n(rst_n[1]),
    .st_valid(st_valid[1]), .st_data(st_data[1]), .st_ready(st_ready[1]),
    .st_out_valid(st_out_valid[1]), .st_out_data(st_out_data[1]), .st_out_ready(st_out_ready[1]),
    .kw_valid(kw_valid[1]), .kw_data(kw_data[1]), .kw_ready(kw_ready[1]),
    .kw_out_valid(kw_out_valid[1]), .kw_out_data(kw_out_data[1])
  );

  // Reference: AES SubBytes / SubWord by table lookup on every byte.
  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX_TBL[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX_TBL[x[8*i +: 8]];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One state job; edge 0 is the accept edge. A key word is offered from edge
  // kw_at on (kw_at < 0: none) until accepted. Returns observed timings.
  task automatic run_job(input int u, input logic [127:0] d, input int kw_at, input logic [31:0] kwd,
                         output int lat, output logic [127:0] res, output int kw_edge,
                         output logic [31:0] kw_res, output int refused);
    logic acc;
    lat = -1; res = 128'h0; kw_edge = -1; kw_res = 32'h0; refused = 0;
    st_out_ready[u] = 1'b1;
    st_valid[u] = 1'b1;
    st_data[u] = d;
    for (int e = 0; e < 40; e++) begin
      if (kw_at >= 0 && e >= kw_at && kw_edge < 0) begin
        kw_valid[u] = 1'b1; kw_data[u] = kwd;
      end else begin
        kw_valid[u] = 1'b0; kw_data[u] = $urandom;
      end
      acc = kw_valid[u] & kw_ready[u];
      if (kw_valid[u] && !kw_ready[u]) refused++;
      tick;
      if (e == 0) begin
        st_valid[u] = 1'b0;
        st_data[u] = {$urandom, $urandom, $urandom, $urandom};
      end
      if (acc) begin
        kw_edge = e;
        if (kw_out_valid[u]) kw_res = kw_out_data[u];
      end
      if (st_out_valid[u] && lat < 0) begin
        lat = e; res = st_out_data[u];
      end
      if (lat >= 0 && (kw_at < 0 || kw_edge >= 0)) break;
    end
    kw_valid[u] = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    st_valid = 2'b00; st_out_ready = 2'b00; kw_valid = 2'b00;
    for (int u = 0; u < 2; u++) begin
      st_data[u] = 128'h0; kw_data[u] = 32'h0;
    end
    #1 rst_n = 2'b00;
    #2;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({st_ready[u], kw_ready[u], st_out_valid[u], kw_out_valid[u]} !== 4'b0000) begin
        $display("FAIL reset_flags[%0d]: got %b expected 0000", u, {st_ready[u], kw_ready[u], st_out_valid[u], kw_out_valid[u]});
      end else passes++;
      checks++;
      if (st_out_data[u] !== 128'h0 || kw_out_data[u] !== 32'h0) begin
        $display("FAIL reset_data[%0d]: got %h/%h expected 0", u, st_out_data[u], kw_out_data[u]);
      end else passes++;
    end
    tick; tick;
    rst_n = 2'b11;
    #1;
    checks++;
    if (st_ready !== 2'b00 || kw_ready !== 2'b00) begin
      $display("FAIL ready_before_edge: got st=%b kw=%b expected 00", st_ready, kw_ready);
    end else passes++;
    tick;
    checks++;
    if (st_ready !== 2'b11 || kw_ready !== 2'b11) begin
      $display("FAIL ready_after_edge: got st=%b kw=%b expected 11", st_ready, kw_ready);
    end else passes++;
  endtask

  task automatic test_zero_state;
    st_out_ready[0] = 1'b1; st_valid[0] = 1'b1; st_data[0] = 128'h0;
    tick;
    st_valid[0] = 1'b0; st_data[0] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k <= 3; k++) begin
      tick;
      checks++;
      if (st_out_valid[0] !== 1'b0) $display("FAIL zero_early_valid: edge %0d got %b expected 0", k, st_out_valid[0]);
      else passes++;
    end
    tick;
    checks++;
    if (st_out_valid[0] !== 1'b1 || st_out_data[0] !== ZERO_OUT) begin
      $display("FAIL zero_result: got v=%b %h expected v=1 %h", st_out_valid[0], st_out_data[0], ZERO_OUT);
    end else passes++;
    checks++;
    if (st_ready[0] !== 1'b0) $display("FAIL zero_ready_in_done: got %b expected 0", st_ready[0]);
    else passes++;
    tick;
    checks++;
    if (st_out_valid[0] !== 1'b0 || st_ready[0] !== 1'b1) begin
      $display("FAIL zero_consume: got v=%b rdy=%b expected v=0 rdy=1", st_out_valid[0], st_ready[0]);
    end else passes++;
  endtask

  task automatic test_fips_state;
    int lat, kwe, refused;
    logic [127:0] res;
    logic [31:0] kwr;
    run_job(0, FIPS_IN, -1, 32'h0, lat, res, kwe, kwr, refused);
    checks++;
    if (lat !== 4 || res !== FIPS_OUT) $display("FAIL fips_state: got lat=%0d %h expected lat=4 %h", lat, res, FIPS_OUT);
    else passes++;
  endtask

  task automatic test_kw_idle;
    logic [31:0] w [2];
    logic [31:0] exp_w [2];
    // SubWord(09cf4f3c) byte-for-byte is 018a84eb; 8a84eb01 is SubWord of the
    // rotated word cf4f3c09 used by key expansion.
    w[0] = 32'h09cf4f3c; exp_w[0] = 32'h018a84eb;
    w[1] = 32'hcf4f3c09; exp_w[1] = 32'h8a84eb01;
    for (int n = 0; n < 2; n++) begin
      kw_valid[0] = 1'b1; kw_data[0] = w[n];
      tick;
      kw_valid[0] = 1'b0; kw_data[0] = $urandom;
      checks++;
      if (kw_out_valid[0] !== 1'b1 || kw_out_data[0] !== exp_w[n] || kw_out_data[0] !== sub_word(w[n])) begin
        $display("FAIL kw_idle: got v=%b %h expected v=1 %h", kw_out_valid[0], kw_out_data[0], exp_w[n]);
      end else passes++;
      tick;
      checks++;
      if (kw_out_valid[0] !== 1'b0 || kw_out_data[0] !== exp_w[n]) begin
        $display("FAIL kw_pulse_end: got v=%b %h expected v=0 %h", kw_out_valid[0], kw_out_data[0], exp_w[n]);
      end else passes++;
    end
  endtask

  task automatic test_preempt_kp1;
    int lat, kwe, refused;
    logic [127:0] res;
    logic [31:0] kwr;
    run_job(0, FIPS_IN, 3, 32'hcf4f3c09, lat, res, kwe, kwr, refused);
    checks++;
    if (kwe !== 3 || refused !== 0 || kwr !== 32'h8a84eb01) begin
      $display("FAIL preempt_kw: got edge=%0d refused=%0d %h expected edge=3 refused=0 8a84eb01", kwe, refused, kwr);
    end else passes++;
    checks++;
    if (lat !== 5 || res !== FIPS_OUT) $display("FAIL preempt_state: got lat=%0d %h expected lat=5 %h", lat, res, FIPS_OUT);
    else passes++;
  endtask

  task automatic test_simultaneous;
    int lat, kwe, refused;
    logic [127:0] res, d;
    logic [31:0] kwr, w;
    d = {$urandom, $urandom, $urandom, $urandom};
    w = $urandom;
    run_job(0, d, 0, w, lat, res, kwe, kwr, refused);
    checks++;
    if (kwe !== 0 || kwr !== sub_word(w)) $display("FAIL simul_kw: got edge=%0d %h expected edge=0 %h", kwe, kwr, sub_word(w));
    else passes++;
    checks++;
    if (lat !== 4 || res !== sub_bytes(d)) $display("FAIL simul_state: got lat=%0d %h expected lat=4 %h", lat, res, sub_bytes(d));
    else passes++;
  endtask

  task automatic test_wait_kp0;
    int lat, kwe, refused;
    logic [127:0] res;
    logic [31:0] kwr;
    run_job(1, FIPS_IN, 3, 32'hcf4f3c09, lat, res, kwe, kwr, refused);
    checks++;
    if (lat !== 4 || res !== FIPS_OUT) $display("FAIL kp0_state: got lat=%0d %h expected lat=4 %h", lat, res, FIPS_OUT);
    else passes++;
    checks++;
    if (refused !== 2 || kwe !== 5 || kwr !== 32'h8a84eb01) begin
      $display("FAIL kp0_kw: got refused=%0d edge=%0d %h expected refused=2 edge=5 8a84eb01", refused, kwe, kwr);
    end else passes++;
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [127:0] d;
    logic [31:0] w;
    d = {$urandom, $urandom, $urandom, $urandom};
    st_out_ready[0] = 1'b1; st_valid[0] = 1'b1; st_data[0] = d;
    tick;
    st_valid[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      w = $urandom;
      kw_valid[0] = 1'b1; kw_data[0] = w;
      tick;
      checks++;
      if (kw_out_valid[0] !== 1'b1 || kw_out_data[0] !== sub_word(w) || st_out_valid[0] !== 1'b0) begin
        $display("FAIL b2b_kw: cycle %0d got kv=%b %h sv=%b expected kv=1 %h sv=0", k, kw_out_valid[0], kw_out_data[0], st_out_valid[0], sub_word(w));
      end else passes++;
    end
    kw_valid[0] = 1'b0;
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      tick;
      if (st_out_valid[0]) begin
        lat = e;
        break;
      end
    end
    checks++;
    if (lat !== 4 || st_out_data[0] !== sub_bytes(d)) begin
      $display("FAIL b2b_state: got lat=%0d %h expected lat=4 %h", lat, st_out_data[0], sub_bytes(d));
    end else passes++;
    tick;
  endtask

  task automatic test_random;
    logic [127:0] d;
    logic [31:0] w;
    logic kv;
    int beats;
    logic done;
    for (int j = 0; j < 12; j++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      beats = 0; done = 1'b0;
      st_out_ready[0] = 1'b1; st_valid[0] = 1'b1; st_data[0] = d;
      for (int e = 0; e < 200 && !done; e++) begin
        kv = ($urandom_range(0, 2) == 0);
        w = $urandom;
        kw_valid[0] = kv; kw_data[0] = w;
        tick;
        if (e == 0) begin
          st_valid[0] = 1'b0; st_data[0] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (e >= 1 && !kv) beats++;
        checks++;
        if (kw_out_valid[0] !== kv || (kv && kw_out_data[0] !== sub_word(w))) begin
          $display("FAIL rand_kw: job %0d edge %0d got v=%b %h expected v=%b %h", j, e, kw_out_valid[0], kw_out_data[0], kv, sub_word(w));
        end else passes++;
        checks++;
        if (beats == 4) begin
          done = 1'b1;
          if (st_out_valid[0] !== 1'b1 || st_out_data[0] !== sub_bytes(d)) begin
            $display("FAIL rand_state: job %0d got v=%b %h expected v=1 %h", j, st_out_valid[0], st_out_data[0], sub_bytes(d));
          end else passes++;
        end else begin
          if (st_out_valid[0] !== 1'b0) $display("FAIL rand_early: job %0d edge %0d got v=%b expected 0", j, e, st_out_valid[0]);
          else passes++;
        end
      end
      kw_valid[0] = 1'b0;
      tick;
    end
  endtask

  task automatic test_hold_reset;
    logic [127:0] d;
    int seen;
    d = {$urandom, $urandom, $urandom, $urandom};
    st_out_ready[0] = 1'b0; st_valid[0] = 1'b1; st_data[0] = d;
    tick;
    st_valid[0] = 1'b0;
    for (int k = 1; k <= 4; k++) tick;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (st_out_valid[0] !== 1'b1 || st_out_data[0] !== sub_bytes(d) || st_ready[0] !== 1'b0) begin
        $display("FAIL hold: cycle %0d got v=%b %h rdy=%b expected v=1 %h rdy=0", k, st_out_valid[0], st_out_data[0], st_ready[0], sub_bytes(d));
      end else passes++;
      if (k < 5) tick;
    end
    st_out_ready[0] = 1'b1;
    tick;
    checks++;
    if (st_out_valid[0] !== 1'b0 || st_ready[0] !== 1'b1) begin
      $display("FAIL hold_release: got v=%b rdy=%b expected v=0 rdy=1", st_out_valid[0], st_ready[0]);
    end else passes++;
    st_valid[0] = 1'b1; st_data[0] = {$urandom, $urandom, $urandom, $urandom};
    tick;
    st_valid[0] = 1'b0;
    tick;
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if ({st_out_valid[0], kw_out_valid[0], st_ready[0], kw_ready[0]} !== 4'b0000 ||
        st_out_data[0] !== 128'h0 || kw_out_data[0] !== 32'h0) begin
      $display("FAIL midjob_reset: got flags=%b %h/%h expected 0000 0/0",
               {st_out_valid[0], kw_out_valid[0], st_ready[0], kw_ready[0]}, st_out_data[0], kw_out_data[0]);
    end else passes++;
    tick;
    rst_n[0] = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (st_out_valid[0]) seen++;
    end
    checks++;
    if (seen !== 0 || st_ready[0] !== 1'b1) $display("FAIL discarded_job: got valids=%0d rdy=%b expected 0 rdy=1", seen, st_ready[0]);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_zero_state();
    test_fips_state();
    test_kw_idle();
    test_preempt_kp1();
    test_simultaneous();
    test_wait_kp0();
    test_back_to_back();
    test_random();
    test_hold_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
